// File: rtl/adder_8bit.sv
// Registered 8-bit adder: two 4-bit carry-lookahead groups, one cycle latency.
// Reset is synchronous and forces the registered result to zero.

module adder_8bit_cla4 (
    input  logic [3:0] g_i,
    input  logic [3:0] p_i,
    input  logic       c_i,
    output logic [3:0] carry_o,
    output logic       c_o
);
    // Every carry is expanded from g/p and the group carry-in, not rippled.
    assign carry_o[0] = c_i;
    assign carry_o[1] = g_i[0] | (p_i[0] & c_i);
    assign carry_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
    assign carry_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                      | (p_i[2] & p_i[1] & p_i[0] & c_i);
    assign c_o        = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                      | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
                      | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & c_i);
endmodule

module adder_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       CIN,
    output logic [7:0] SUM,
    output logic       COUT
);
    logic [7:0] gen, prop, carry;
    logic       c4, cout_d, cout_q;
    logic [7:0] sum_d, sum_q;

    assign gen  = A & B;
    assign prop = A ^ B;

    adder_8bit_cla4 u_lo (
        .g_i     (gen[3:0]),
        .p_i     (prop[3:0]),
        .c_i     (CIN),
        .carry_o (carry[3:0]),
        .c_o     (c4)
    );

    adder_8bit_cla4 u_hi (
        .g_i     (gen[7:4]),
        .p_i     (prop[7:4]),
        .c_i     (c4),
        .carry_o (carry[7:4]),
        .c_o     (cout_d)
    );

    assign sum_d = prop ^ carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 8'h00;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign SUM  = sum_q;
    assign COUT = cout_q;
endmodule

// File: tb/tb_adder_8bit.sv
// Bench for adder_8bit: vector table plus random run, checked through a scoreboard queue.

module tb_adder_8bit;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A, B;
    logic       CIN;
    logic [7:0] SUM;
    logic       COUT;

    adder_8bit dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .CIN  (CIN),
        .SUM  (SUM),
        .COUT (COUT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       rst;
        logic [8:0] exp;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] sb_q[$];
    logic [8:0] last_exp;
    bit         have_last = 1'b0;
    vec_t       tbl[14];

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got cout=%0b sum=%02h, want cout=%0b sum=%02h",
                     name, act[8], act[7:0], exp[8], exp[7:0]);
        end
    endtask

    // Drive one cycle of stimulus; the result is popped one edge later.
    task automatic step(input string name, input logic r, input logic [7:0] a,
                        input logic [7:0] b, input logic c, input logic [8:0] exp);
        logic [8:0] e;
        rst = r; A = a; B = b; CIN = c;
        sb_q.push_back(exp);
        #1;
        if (have_last) check({name, "/hold"}, {COUT, SUM}, last_exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check(name, {COUT, SUM}, e);
            last_exp  = e;
            have_last = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ra, rb;
        logic       rc, rr;
        tbl[0]  = '{8'hAA, 8'h55, 1'b1, 1'b1, 9'h000};
        tbl[1]  = '{8'hAA, 8'h55, 1'b1, 1'b1, 9'h000};
        tbl[2]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 9'h010};
        tbl[3]  = '{8'h0F, 8'h00, 1'b1, 1'b0, 9'h010};
        tbl[4]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 9'h100};
        tbl[5]  = '{8'h80, 8'h80, 1'b1, 1'b0, 9'h101};
        tbl[6]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF};
        tbl[7]  = '{8'h12, 8'h34, 1'b0, 1'b0, 9'h046};
        tbl[8]  = '{8'hF0, 8'h10, 1'b1, 1'b0, 9'h101};
        tbl[9]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 9'h080};
        tbl[10] = '{8'h00, 8'h00, 1'b0, 1'b0, 9'h000};
        tbl[11] = '{8'h55, 8'hAA, 1'b0, 1'b0, 9'h0FF};
        tbl[12] = '{8'h55, 8'hAA, 1'b1, 1'b0, 9'h100};
        tbl[13] = '{8'hFF, 8'h00, 1'b0, 1'b0, 9'h0FF};

        rst = 1'b1; A = 8'h00; B = 8'h00; CIN = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp);

        // Reset in the middle of a stream discards the pending sum, then recovery.
        step("mid_pre",  1'b0, 8'h11, 8'h22, 1'b0, 9'h033);
        step("mid_rst",  1'b1, 8'hC8, 8'h64, 1'b1, 9'h000);
        step("mid_rel",  1'b0, 8'hC8, 8'h64, 1'b1, 9'h12D);
        step("mid_rst2", 1'b1, 8'hFF, 8'hFF, 1'b1, 9'h000);
        step("mid_rel2", 1'b0, 8'hFF, 8'hFF, 1'b1, 9'h1FF);

        for (int i = 0; i < 1200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rr = ($urandom_range(0, 49) == 0);
            step($sformatf("rnd%0d", i), rr, ra, rb, rc,
                 rr ? 9'h000 : ({1'b0, ra} + {1'b0, rb} + {8'h00, rc}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_8bit.md
ADDER_8BIT -- requirements
Module: adder_8bit

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A  input  8  operand A, unsigned.
REQ-005 B  input  8  operand B, unsigned.
REQ-006 CIN  input  1  carry-in, weight 1.
REQ-007 SUM  output  8  registered low 8 bits of A+B+CIN.
REQ-008 COUT  output  1  registered carry-out, bit 8 of A+B+CIN.
REQ-009 The block SHALL use one clock, clk. Reset rst SHALL be synchronous and active-high, sampled only on the rising edge of clk.

Function
REQ-010 On every rising edge of clk with rst=0, the block SHALL register {COUT,SUM} = A + B + CIN, evaluated as 9-bit unsigned arithmetic on the values of A, B and CIN present at that edge.
REQ-011 Latency SHALL be exactly one clock: the result for inputs sampled at edge N SHALL appear on SUM/COUT after edge N and hold until edge N+1.
REQ-012 No handshake: a new operation SHALL be accepted on every cycle, giving a throughput of one result per clock.
REQ-013 The carry path SHALL be two 4-bit carry-lookahead groups, bits [3:0] and [7:4], built from per-bit generate (A&B) and propagate (A^B) terms.
REQ-014 The group carry c4 SHALL feed the upper group, and COUT SHALL be the upper group's carry-out.
REQ-015 SUM[i] SHALL equal propagate[i] XOR carry[i], with carry[0] = CIN.
REQ-016 Wrap-around: when A+B+CIN >= 256, SUM SHALL equal (A+B+CIN) - 256 and COUT SHALL be 1; otherwise COUT SHALL be 0.
REQ-017 Maximum case: A=0xFF, B=0xFF, CIN=1 SHALL give SUM=0xFF, COUT=1; no result width may exceed 9 bits.
REQ-018 The outputs SHALL be pure functions of the registered result, with no combinational path from A, B, CIN or rst to SUM or COUT.
REQ-019 Inputs X/Z are outside the contract; the block SHALL NOT be required to handle them.

Reset
REQ-020 When rst=1 at a rising edge of clk, SUM SHALL become 0x00 and COUT SHALL become 0 after that edge, regardless of A, B and CIN.
REQ-021 Reset SHALL take priority over computation on the same edge.
REQ-022 If reset is asserted mid-stream, the result from the pending inputs SHALL be discarded.
REQ-023 On the first edge with rst=0, the block SHALL register the sum of the inputs present at that edge.
REQ-024 Until the first rising edge with rst=1, the output values SHALL be undefined; the bench SHALL apply reset before checking.

Verification
REQ-025 Reset check: rst=1 for 2 cycles with A=0xAA, B=0x55, CIN=1 -> SUM=0x00, COUT=0 after each of those edges.
REQ-026 Nibble carry: A=0x0F, B=0x01, CIN=0 -> one cycle later SUM=0x10, COUT=0; A=0x0F, B=0x00, CIN=1 -> SUM=0x10, COUT=0.
REQ-027 Wrap: A=0xFF, B=0x01, CIN=0 -> SUM=0x00, COUT=1; A=0x80, B=0x80, CIN=1 -> SUM=0x01, COUT=1; A=0xFF, B=0xFF, CIN=1 -> SUM=0xFF, COUT=1.
REQ-028 Back-to-back: apply (0x12,0x34,0), (0xF0,0x10,1), (0x7F,0x01,0) on consecutive edges -> outputs on consecutive cycles SHALL be (0x46,0), (0x01,1), (0x80,0).
REQ-029 Reset mid-stream: apply A=0xC8, B=0x64, CIN=1 with rst=1 on the same edge -> SUM=0x00, COUT=0; deassert rst with inputs held -> next cycle SUM=0x2D, COUT=1.
REQ-030 Random run: at least 1000 cycles of random A, B, CIN, with each output compared against a 9-bit reference sum of the previous cycle's inputs; zero mismatches SHALL be required.
